// File: rtl/alu_share_arb_if.sv
// Bundles the two requester channels, the tagged response channel, the ALU hookup and the
// architectural flag outputs of alu_share_arb.
interface alu_share_arb_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [2:0]  req0_op;
   logic [15:0] req0_a;
   logic [15:0] req0_b;
   logic        req1_valid;
   logic        req1_ready;
   logic [2:0]  req1_op;
   logic [15:0] req1_a;
   logic [15:0] req1_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [15:0] rsp_data;
   logic [2:0]  rsp_flags;
   logic [15:0] alu_in1;
   logic [15:0] alu_in2;
   logic [2:0]  alu_opcode;
   logic [15:0] alu_out;
   logic [2:0]  alu_flags;
   logic        alu_flags_set;
   logic [2:0]  flags_q;
   logic        flags_busy;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  rsp_ready, alu_out, alu_flags, alu_flags_set,
      output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_flags,
      output alu_in1, alu_in2, alu_opcode, flags_q, flags_busy
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output rsp_ready, alu_out, alu_flags, alu_flags_set,
      input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_flags,
      input  alu_in1, alu_in2, alu_opcode, flags_q, flags_busy
   );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin scheduler sharing one combinational 16-bit ALU between two requesters; owns the
// architectural Z/N/V flag register and the flag-busy stall indication.
module alu_share_arb #(
   parameter logic [1:0] FLAG_WRITERS = 2'b01
) (
   input logic            clk,
   input logic            rst_n,
   alu_share_arb_if.slave bus
);
   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StExec = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   localparam logic [2:0] OpRed    = 3'b011;
   localparam logic [2:0] OpPaddsb = 3'b111;

   logic [1:0]  state_q, state_d;
   logic        last_grant_q;
   logic [2:0]  op_q;
   logic [15:0] a_q, b_q;
   logic        id_q;
   logic [15:0] rsp_data_q;
   logic [2:0]  rsp_flags_q;
   logic [2:0]  arch_flags_q;

   logic        grant0, grant1, handshake, gnt_id, flag_load;
   logic [2:0]  gnt_op;

   // Tie goes to the requester not granted last; gated by rst_n so ready stays low in reset.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst_n && state_q == StIdle) begin
         if (bus.req0_valid && bus.req1_valid) begin
            grant0 = last_grant_q;
            grant1 = ~last_grant_q;
         end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
         end
      end
   end

   assign handshake = grant0 | grant1;
   assign gnt_id    = grant1;
   assign gnt_op    = grant1 ? bus.req1_op : bus.req0_op;
   assign flag_load = (state_q == StExec) && bus.alu_flags_set && FLAG_WRITERS[id_q];

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign bus.flags_busy = flag_load ||
                           (handshake && FLAG_WRITERS[gnt_id] &&
                            gnt_op != OpRed && gnt_op != OpPaddsb);

   assign bus.rsp_valid  = (state_q == StResp);
   assign bus.rsp_id     = id_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign bus.alu_in1    = a_q;
   assign bus.alu_in2    = b_q;
   assign bus.alu_opcode = op_q;
   assign bus.flags_q    = arch_flags_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (handshake) state_d = StExec;
         StExec:  state_d = StResp;
         StResp:  if (bus.rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         op_q         <= 3'd0;
         a_q          <= 16'd0;
         b_q          <= 16'd0;
         id_q         <= 1'b0;
         rsp_data_q   <= 16'd0;
         rsp_flags_q  <= 3'd0;
         arch_flags_q <= 3'd0;
      end else begin
         state_q <= state_d;
         if (handshake) begin
            op_q         <= gnt_op;
            a_q          <= grant1 ? bus.req1_a : bus.req0_a;
            b_q          <= grant1 ? bus.req1_b : bus.req0_b;
            id_q         <= gnt_id;
            last_grant_q <= gnt_id;
         end
         if (state_q == StExec) begin
            rsp_data_q  <= bus.alu_out;
            rsp_flags_q <= bus.alu_flags;
         end
         if (flag_load) arch_flags_q <= bus.alu_flags;
      end
   end
endmodule
